// File: rtl/inst_buffer_if.sv
// Fetch/decode-side bundle for inst_buffer. The master modport is the
// fetch + decode environment. The slave modport is the buffer itself.
// Latency/backpressure: none (wires only). Push is gated by buffer_full_o.
interface inst_buffer_if;
    // fetch side (two slots per cycle)
    logic        fetch_valid1_i;
    logic        fetch_valid2_i;
    logic [31:0] fetch_inst1_i;
    logic [31:0] fetch_inst2_i;
    logic [31:0] fetch_pc1_i;
    logic [31:0] fetch_pc2_i;
    logic        fetch_exc1_i;
    logic        fetch_exc2_i;
    logic        buffer_full_o;
    // decode side (head and head+1)
    logic        issue_en_i;
    logic        issue_dual_i;
    logic        valid1_o;
    logic        valid2_o;
    logic [31:0] inst1_o;
    logic [31:0] inst2_o;
    logic [31:0] pc1_o;
    logic [31:0] pc2_o;
    logic        exc1_o;
    logic        exc2_o;

    modport master (
        output fetch_valid1_i, fetch_valid2_i, fetch_inst1_i, fetch_inst2_i,
               fetch_pc1_i, fetch_pc2_i, fetch_exc1_i, fetch_exc2_i,
               issue_en_i, issue_dual_i,
        input  buffer_full_o, valid1_o, valid2_o, inst1_o, inst2_o,
               pc1_o, pc2_o, exc1_o, exc2_o
    );

    modport slave (
        input  fetch_valid1_i, fetch_valid2_i, fetch_inst1_i, fetch_inst2_i,
               fetch_pc1_i, fetch_pc2_i, fetch_exc1_i, fetch_exc2_i,
               issue_en_i, issue_dual_i,
        output buffer_full_o, valid1_o, valid2_o, inst1_o, inst2_o,
               pc1_o, pc2_o, exc1_o, exc2_o
    );
endinterface

// File: rtl/inst_buffer.sv
// Dual-ported instruction queue between fetch (2 pushes/cycle) and dual-issue decode (2 pops/cycle).
// Latency: a push at edge N is visible on the head outputs after edge N. There is no same-cycle bypass.
// Backpressure: buffer_full_o (fewer than 2 free entries, from registered count) blocks pushes. Pushes while full are dropped.
//
// Ports:
//   clk, resetn   clock; asynchronous active-low reset (pointers/count only)
//   flush         empties the queue at the next edge. Same-cycle push/pop are ignored.
//   bus (slave)   fetch slots 1/2 in, buffer_full_o out; issue_en_i/issue_dual_i in,
//                 head/head+1 {valid, inst, pc, exc} out (zero when invalid)
module inst_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush,
    inst_buffer_if.slave bus
);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        exc;
    } entry_t;

    localparam logic [PTR_W:0]   FULL_THR = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W:0]   count;

    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;
    logic [1:0]       push_n;
    logic [1:0]       push_acc;
    logic [1:0]       pop_n;
    logic             full;
    logic             valid1;
    logic             valid2;
    entry_t           rd1;
    entry_t           rd2;
    entry_t           wr1;
    entry_t           wr2;

    assign head_p1 = head_ptr + PTR_ONE;
    assign tail_p1 = tail_ptr + PTR_ONE;
    assign full    = count > FULL_THR;
    assign valid1  = count != '0;
    assign valid2  = count > CNT_ONE;

    always_comb begin
        // Slot 2 only counts when slot 1 is also valid. This gives a count of 0, 1 or 2.
        push_n = {bus.fetch_valid1_i & bus.fetch_valid2_i,
                  bus.fetch_valid1_i & ~bus.fetch_valid2_i};
        // A push against a full buffer is dropped whole. Flush also cancels it.
        push_acc = (full || flush) ? 2'd0 : push_n;

        // A dual-issue request with only one valid entry retires just that entry.
        pop_n = 2'd0;
        if (bus.issue_en_i && valid1)
            pop_n = (bus.issue_dual_i && valid2) ? 2'd2 : 2'd1;
    end

    assign wr1 = '{inst: bus.fetch_inst1_i, pc: bus.fetch_pc1_i, exc: bus.fetch_exc1_i};
    assign wr2 = '{inst: bus.fetch_inst2_i, pc: bus.fetch_pc2_i, exc: bus.fetch_exc2_i};

    // Storage is intentionally not reset. The count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_acc != 2'd0)
            mem[tail_ptr] <= wr1;
        if (push_acc == 2'd2)
            mem[tail_p1] <= wr2;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            head_ptr <= head_ptr + PTR_W'(pop_n);
            tail_ptr <= tail_ptr + PTR_W'(push_acc);
            count    <= count + (PTR_W+1)'(push_acc) - (PTR_W+1)'(pop_n);
        end
    end

    assign rd1 = mem[head_ptr];
    assign rd2 = mem[head_p1];

    assign bus.buffer_full_o = full;
    assign bus.valid1_o      = valid1;
    assign bus.valid2_o      = valid2;
    assign bus.inst1_o       = valid1 ? rd1.inst : '0;
    assign bus.pc1_o         = valid1 ? rd1.pc   : '0;
    assign bus.exc1_o        = valid1 & rd1.exc;
    assign bus.inst2_o       = valid2 ? rd2.inst : '0;
    assign bus.pc2_o         = valid2 ? rd2.pc   : '0;
    assign bus.exc2_o        = valid2 & rd2.exc;

endmodule

// File: tb/tb_inst_buffer.sv
// Testbench for inst_buffer. Entries are queued when fetch pushes them and removed at issue.
// The queue head is compared with the DUT outputs on every cycle.
// Outputs are sampled 1 ns after the rising edge.
module tb_inst_buffer;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        exc;
    } ent_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic flush = 1'b0;

    inst_buffer_if bus ();

    inst_buffer #(.DEPTH(DEPTH), .PTR_W(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    ent_t        sb[$];
    logic [31:0] nxt_pc = 32'hBFC00000;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'h24010001 + ((pc - 32'hBFC00000) >> 2) * 32'h00010001;
    endfunction

    task automatic check_outputs();
        check("valid1", 32'(bus.valid1_o), 32'(sb.size() >= 1));
        check("valid2", 32'(bus.valid2_o), 32'(sb.size() >= 2));
        check("full",   32'(bus.buffer_full_o), 32'(sb.size() > DEPTH - 2));
        if (sb.size() >= 1) begin
            check("pc1",   bus.pc1_o,   sb[0].pc);
            check("inst1", bus.inst1_o, sb[0].inst);
            check("exc1",  32'(bus.exc1_o), 32'(sb[0].exc));
        end else begin
            check("pc1_zero",   bus.pc1_o,   32'h0);
            check("inst1_zero", bus.inst1_o, 32'h0);
            check("exc1_zero",  32'(bus.exc1_o), 32'h0);
        end
        if (sb.size() >= 2) begin
            check("pc2",   bus.pc2_o,   sb[1].pc);
            check("inst2", bus.inst2_o, sb[1].inst);
            check("exc2",  32'(bus.exc2_o), 32'(sb[1].exc));
        end else begin
            check("pc2_zero",   bus.pc2_o,   32'h0);
            check("inst2_zero", bus.inst2_o, 32'h0);
            check("exc2_zero",  32'(bus.exc2_o), 32'h0);
        end
    endtask

    // One clock cycle. The task checks the current outputs, drives the inputs,
    // updates the reference queue and advances to 1 ns past the next edge.
    task automatic cyc(input logic v1, input logic v2, input logic ie, input logic dual,
                       input logic fl, input logic e1 = 1'b0, input logic e2 = 1'b0);
        int   np;
        bit   full_m;
        ent_t e;
        check_outputs();
        bus.fetch_valid1_i = v1;
        bus.fetch_valid2_i = v2;
        bus.fetch_pc1_i    = nxt_pc;
        bus.fetch_pc2_i    = nxt_pc + 32'd4;
        bus.fetch_inst1_i  = inst_of(nxt_pc);
        bus.fetch_inst2_i  = inst_of(nxt_pc + 32'd4);
        bus.fetch_exc1_i   = e1;
        bus.fetch_exc2_i   = e2;
        bus.issue_en_i     = ie;
        bus.issue_dual_i   = dual;
        flush              = fl;
        full_m = sb.size() > DEPTH - 2;
        if (fl) begin
            sb.delete();
        end else begin
            np = 0;
            if (ie && sb.size() >= 1) np = (dual && sb.size() >= 2) ? 2 : 1;
            for (int i = 0; i < np; i++) begin
                e = sb.pop_front();
                if (i == 0) check("issue1_pc", bus.pc1_o, e.pc);
                else        check("issue2_pc", bus.pc2_o, e.pc);
            end
            if (v1 && !full_m) begin
                sb.push_back('{inst: inst_of(nxt_pc), pc: nxt_pc, exc: e1});
                if (v2) sb.push_back('{inst: inst_of(nxt_pc + 32'd4), pc: nxt_pc + 32'd4, exc: e2});
                nxt_pc = nxt_pc + (v2 ? 32'd8 : 32'd4);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.fetch_valid1_i = 1'b0; bus.fetch_valid2_i = 1'b0;
        bus.fetch_inst1_i  = '0;   bus.fetch_inst2_i  = '0;
        bus.fetch_pc1_i    = '0;   bus.fetch_pc2_i    = '0;
        bus.fetch_exc1_i   = 1'b0; bus.fetch_exc2_i   = 1'b0;
        bus.issue_en_i     = 1'b0; bus.issue_dual_i   = 1'b0;

        // Reset state.
        #12;
        check("rst_valid1", 32'(bus.valid1_o), 32'h0);
        check("rst_pc1",    bus.pc1_o, 32'h0);
        check("rst_full",   32'(bus.buffer_full_o), 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // Dual push with no issue. Then a single pop. Then a dual request with one entry left.
        cyc(1, 1, 0, 0, 0);
        check("push_pc2", bus.pc2_o, 32'hBFC00004);
        cyc(0, 0, 1, 0, 0);
        check("pop1_pc1", bus.pc1_o, 32'hBFC00004);
        cyc(0, 0, 1, 1, 0);
        check("drain_valid1", 32'(bus.valid1_o), 32'h0);
        // Slot 2 alone is ignored.
        cyc(0, 1, 0, 0, 0);

        // Fill to DEPTH with dual pushes. A further push must be dropped.
        nxt_pc = 32'hBFC00000;
        for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 0);
        check("fill_full", 32'(bus.buffer_full_o), 32'h1);
        cyc(1, 1, 0, 0, 0);
        check("fill_head", bus.pc1_o, 32'hBFC00000);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 1, 0);

        // Offset the pointers by one, so that dual transfers straddle the wrap point.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        nxt_pc = 32'hBFC00000;
        for (int i = 0; i < 20; i++) cyc(1, 1, 1, 1, 0);

        // Fill to 10 or more. Then flush together with a push and an issue.
        for (int i = 0; i < 8 && sb.size() < 10; i++) cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 1, 1, 1);
        check("flush_valid1", 32'(bus.valid1_o), 32'h0);
        cyc(1, 0, 0, 0, 0);
        check("post_flush_valid2", 32'(bus.valid2_o), 32'h0);
        cyc(0, 0, 1, 0, 0);

        // Fill to full. Then flush with no push and no issue.
        for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        check("flush_full", 32'(bus.buffer_full_o), 32'h0);

        // Exception entry. Then an asynchronous reset between edges.
        nxt_pc = 32'h00000003;
        cyc(1, 0, 0, 0, 0, 1'b1);
        check_outputs();
        check("exc_flag", 32'(bus.exc1_o), 32'h1);
        check("exc_pc",   bus.pc1_o, 32'h00000003);
        #2;
        resetn = 1'b0;
        #1;
        sb.delete();
        check("arst_valid1", 32'(bus.valid1_o), 32'h0);
        check("arst_pc1",    bus.pc1_o, 32'h0);
        check("arst_exc1",   32'(bus.exc1_o), 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        nxt_pc = 32'hBFC00100;
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        check_outputs();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/inst_buffer.md
# inst_buffer

Dual-ported instruction queue between fetch and decode. Accepts up to two fetched instructions per cycle, presents the oldest two to the dual-issue decode stage, and retires one or two entries per cycle according to the decode stage's issue decision. Decouples I-cache fetch latency from the decode → ID/EX pipeline register and empties on pipeline flush (branch mispredict or exception).

## Interface
- DEPTH, 16, number of entries; power of two, ≥ 4
- PTR_W, 4, log2(DEPTH)

- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  discard every entry this cycle
- fetch_valid1_i  in  1  fetch slot 1 carries an instruction
- fetch_valid2_i  in  1  fetch slot 2 carries an instruction; ignored unless fetch_valid1_i=1
- fetch_inst1_i / fetch_inst2_i  in  32  instruction words
- fetch_pc1_i / fetch_pc2_i  in  32  instruction addresses
- fetch_exc1_i / fetch_exc2_i  in  1  fetch address error for that slot
- buffer_full_o  out  1  fewer than 2 free entries; fetch must not push
- issue_en_i  in  1  decode accepts this cycle (stall[2] deasserted)
- issue_dual_i  in  1  1 = decode consumes two entries, 0 = one
- valid1_o / valid2_o  out  1  head / head+1 entry present
- inst1_o / inst2_o  out  32  head / head+1 instruction; 0 when invalid
- pc1_o / pc2_o  out  32  head / head+1 PC; 0 when invalid
- exc1_o / exc2_o  out  1  head / head+1 fetch exception; 0 when invalid

## Operation
- Storage: DEPTH-entry circular array of {inst, pc, exc}; registered head_ptr, tail_ptr (PTR_W bits, wrap modulo DEPTH) and count (PTR_W+1 bits).
- push_n = fetch_valid1_i + (fetch_valid1_i & fetch_valid2_i); slot 1 written at tail, slot 2 at tail+1 (wrapping); tail += push_n.
- Push while buffer_full_o=1: entire push discarded, pointers unchanged (protocol violation, not an error state).
- valid1_o = count≥1; valid2_o = count≥2; outputs read combinationally from array at head, head+1.
- pop_n = 0 if !issue_en_i or !valid1_o; else 2 if issue_dual_i & valid2_o; else 1. issue_dual_i with only one valid entry pops one.
- head += pop_n; count_next = count + push_n − pop_n; never exceeds DEPTH, never underflows.
- buffer_full_o = count > DEPTH−2, from registered count (no credit for same-cycle pop).
- flush: highest priority after reset; head=tail=count=0 next edge; same-cycle push and pop ignored.
- Array contents not reset; only pointers/count. Outputs gated to 0 when invalid.

## Timing
- Reset (async assert): head=tail=count=0; valid1_o=valid2_o=0; inst/pc/exc outputs 0; buffer_full_o=0. Deassertion takes effect at next rising edge.
- Push → visible: entry pushed at edge N appears on outputs after edge N (no same-cycle bypass when empty).
- Pop: entries on outputs during cycle N retire at edge N when issue_en_i=1; next entries visible after that edge.
- Simultaneous push and pop: both applied; count reflects net change.
- Wrap-around: tail/head roll from DEPTH−1 to 0; a two-entry push or pop straddling the boundary writes/reads entries DEPTH−1 and 0.
- Flush with reset low: reset wins. Flush coincident with full: empties in one cycle, buffer_full_o=0 next cycle.

## Test plan
- Reset then push {pc 0xBFC00000, inst 0x24010001} + {0xBFC00004, 0x24020002}, issue_en_i=0 → next cycle valid1_o=valid2_o=1, pc1_o=0xBFC00000, pc2_o=0xBFC00004, buffer_full_o=0.
- With 2 entries, issue_en_i=1, issue_dual_i=0 for one cycle → pc1_o=0xBFC00004, valid2_o=0; then issue_dual_i=1 → pops one, valid1_o=0, all outputs 0.
- Dual-push 8 cycles without issue (DEPTH=16) → count 16, buffer_full_o=1 from count 15; further push ignored, head still 0xBFC00000.
- Steady state dual push + dual pop for 20 cycles → PCs issue in strict order 0xBFC00000, +4, … across pointer wrap; count constant.
- Fill 10 entries, assert flush together with push and issue_en_i=1 → next cycle valid1_o=0, buffer_full_o=0; following push appears alone at head.
- Push slot with fetch_exc1_i=1 at pc 0x00000003 → exc1_o=1, pc1_o=0x00000003; assert resetn=0 mid-stream → outputs zero immediately, without a clock edge.
